// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional baud-rate oversample tick generator
// Emits oversample, bit-centre and bit-end ticks from an integer+fractional clock divisor.
module baud_tick_gen #(
    parameter int SIZE_BAUD  = 24,
    parameter int SIZE_FRAC  = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [SIZE_BAUD-1:0]          i_div_int,
    input  logic [SIZE_FRAC-1:0]          i_div_frac,
    input  logic                          i_resync,
    output logic                          o_os_tick,
    output logic                          o_mid_tick,
    output logic                          o_bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_phase,
    output logic                          o_cfg_err
);

    localparam int PW = $clog2(OVERSAMPLE);

    logic [SIZE_BAUD-1:0] cnt_q, cnt_d;
    logic [SIZE_FRAC-1:0] acc_q, acc_d;
    logic                 ext_q, ext_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic                 os_tick_q, os_tick_d;
    logic                 mid_tick_q, mid_tick_d;
    logic                 bit_tick_q, bit_tick_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 legal;
    logic [SIZE_BAUD:0]   limit;
    logic                 terminal;
    logic [SIZE_FRAC:0]   frac_sum;

    always_comb begin
        legal    = (i_div_int >= SIZE_BAUD'(2));
        // One bit wider than the divisor so div_int-1+extend never wraps.
        limit    = {1'b0, i_div_int} - {{SIZE_BAUD{1'b0}}, 1'b1} + {{SIZE_BAUD{1'b0}}, ext_q};
        terminal = ({1'b0, cnt_q} >= limit);
        frac_sum = {1'b0, acc_q} + {1'b0, i_div_frac};

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        phase_d    = phase_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        cfg_err_d  = ~legal;

        if (i_resync || !legal) begin
            cnt_d   = '0;
            acc_d   = '0;
            ext_d   = 1'b0;
            phase_d = '0;
        end else if (i_en) begin
            if (terminal) begin
                cnt_d      = '0;
                acc_d      = frac_sum[SIZE_FRAC-1:0];
                ext_d      = frac_sum[SIZE_FRAC];
                phase_d    = (phase_q == PW'(OVERSAMPLE - 1)) ? '0 : phase_q + PW'(1);
                os_tick_d  = 1'b1;
                mid_tick_d = (phase_q == PW'(OVERSAMPLE / 2 - 1));
                bit_tick_d = (phase_q == PW'(OVERSAMPLE - 1));
            end else begin
                cnt_d = cnt_q + SIZE_BAUD'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            phase_q    <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ext_q      <= ext_d;
            phase_q    <= phase_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_os_tick  = os_tick_q;
    assign o_mid_tick = mid_tick_q;
    assign o_bit_tick = bit_tick_q;
    assign o_phase    = phase_q;
    assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - self-checking bench for baud_tick_gen
// Compares every cycle against a period-based reference model, plus directed timing checks.
module tb_baud_tick_gen;

    localparam int SB = 24;
    localparam int SF = 4;
    localparam int OS = 16;
    localparam int PW = $clog2(OS);

    logic          clk = 1'b0;
    logic          rst, en, resync;
    logic [SB-1:0] div_int;
    logic [SF-1:0] div_frac;
    logic          os_tick, mid_tick, bit_tick, cfg_err;
    logic [PW-1:0] phase;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    baud_tick_gen #(.SIZE_BAUD(SB), .SIZE_FRAC(SF), .OVERSAMPLE(OS)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_div_int(div_int),
        .i_div_frac(div_frac), .i_resync(resync), .o_os_tick(os_tick),
        .o_mid_tick(mid_tick), .o_bit_tick(bit_tick), .o_phase(phase),
        .o_cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: clocks elapsed in the current period, period = div + carry of the
    // running fractional sum, total ticks since alignment gives the phase.
    int elapsed, frac_sum, ticks;
    bit extend;
    bit e_os, e_mid, e_bit, e_err;

    task automatic model_step();
        e_os = 0; e_mid = 0; e_bit = 0;
        if (rst) begin
            elapsed = 0; frac_sum = 0; extend = 0; ticks = 0; e_err = 0;
        end else begin
            e_err = (div_int < 2);
            if (resync || div_int < 2) begin
                elapsed = 0; frac_sum = 0; extend = 0; ticks = 0;
            end else if (en) begin
                if (elapsed + 1 >= int'(div_int) + int'(extend)) begin
                    e_os  = 1;
                    e_mid = (ticks % OS) == OS / 2 - 1;
                    e_bit = (ticks % OS) == OS - 1;
                    ticks++;
                    extend   = (frac_sum + int'(div_frac)) >= (1 << SF);
                    frac_sum = (frac_sum + int'(div_frac)) % (1 << SF);
                    elapsed  = 0;
                end else begin
                    elapsed++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("os_tick", 32'(os_tick), 32'(e_os));
        check("mid_tick", 32'(mid_tick), 32'(e_mid));
        check("bit_tick", 32'(bit_tick), 32'(e_bit));
        check("phase", 32'(phase), 32'(ticks % OS));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
    endtask

    task automatic do_reset();
        rst = 1; en = 1; resync = 0;
        cyc();
        rst = 0;
    endtask

    initial begin
        int first_os, first_mid, first_bit, n_os, found;
        int tq[$];

        rst = 1; en = 0; resync = 0; div_int = 4; div_frac = 0;
        repeat (3) cyc();
        rst = 0; en = 1;

        // Integer divisor 4: os every 4, mid at 32, bit at 64.
        first_os = -1; first_mid = -1; first_bit = -1; n_os = 0;
        for (int i = 1; i <= 200; i++) begin
            cyc();
            if (os_tick) n_os++;
            if (os_tick && first_os < 0) first_os = i;
            if (mid_tick && first_mid < 0) first_mid = i;
            if (bit_tick && first_bit < 0) first_bit = i;
        end
        check("first_os_div4", 32'(first_os), 32'd4);
        check("first_mid_div4", 32'(first_mid), 32'd32);
        check("first_bit_div4", 32'(first_bit), 32'd64);
        check("os_count_200", 32'(n_os), 32'd50);

        // Fractional divisor 4.5: 16 oversample periods span 72 clocks.
        div_frac = 8;
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            cyc();
            if (os_tick) tq.push_back(i);
        end
        check("frac_span16", 32'(tq[16] - tq[0]), 32'd72);
        check("frac_p1", 32'(tq[1] - tq[0]), 32'd4);
        check("frac_p2", 32'(tq[2] - tq[1]), 32'd5);

        // Lowering the divisor below the running count ticks on the next edge.
        div_frac = 0; div_int = 100;
        do_reset();
        repeat (50) cyc();
        div_int = 10;
        cyc();
        check("lower_tick", 32'(os_tick), 32'd1);
        n_os = 0;
        repeat (9) begin cyc(); if (os_tick) n_os++; end
        check("lower_quiet", 32'(n_os), 32'd0);
        cyc();
        check("lower_period", 32'(os_tick), 32'd1);

        // Resync at phase 11.
        div_int = 4;
        do_reset();
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (phase == 11) found = 1;
        end
        check("reach_phase11", 32'(found), 32'd1);
        resync = 1;
        cyc();
        check("resync_no_tick", 32'(os_tick), 32'd0);
        check("resync_phase", 32'(phase), 32'd0);
        resync = 0;
        first_mid = -1; first_bit = -1;
        for (int i = 1; i <= 70; i++) begin
            cyc();
            if (mid_tick && first_mid < 0) first_mid = i;
            if (bit_tick && first_bit < 0) first_bit = i;
        end
        check("resync_mid", 32'(first_mid), 32'd32);
        check("resync_bit", 32'(first_bit), 32'd64);

        // Illegal divisor then recovery.
        div_int = 1;
        cyc();
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        n_os = 0;
        repeat (10) begin cyc(); if (os_tick) n_os++; end
        check("cfg_err_quiet", 32'(n_os), 32'd0);
        div_int = 3;
        first_os = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 1) check("cfg_err_clear", 32'(cfg_err), 32'd0);
            if (os_tick && first_os < 0) first_os = i;
        end
        check("restart_first_os", 32'(first_os), 32'd3);

        // Reset mid-period with enable toggling.
        div_int = 7;
        for (int i = 0; i < 23; i++) begin en = i[0] | i[2]; cyc(); end
        rst = 1; en = 1;
        cyc();
        check("rst_all_zero", {27'd0, os_tick, mid_tick, bit_tick, cfg_err, |phase}, 32'd0);
        rst = 0; div_int = 5;
        first_os = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (os_tick && first_os < 0) first_os = i;
        end
        check("rst_restart_os", 32'(first_os), 32'd5);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) div_int = SB'($urandom_range(2, 9));
            if ($urandom_range(0, 99) < 1) div_int = SB'($urandom_range(0, 1));
            if (div_int < 2 && $urandom_range(0, 99) < 20) div_int = SB'($urandom_range(2, 6));
            if ($urandom_range(0, 99) < 3) div_frac = SF'($urandom);
            en     = ($urandom_range(0, 99) < 90);
            resync = ($urandom_range(0, 99) < 2);
            rst    = ($urandom_range(0, 999) < 5);
            cyc();
        end
        rst = 0; resync = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
